// File: rtl/shift_pkg.sv
// Shared definitions for the shared-shifter arbiter slice.
// Contents: shift direction encodings, datapath widths, the request bundle
// type, the response-slot state type and the saturating grant-counter helper.
package shift_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              dir;
  } shift_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational logical barrel shifter (zero fill, no rotate).
// Ports:
//   data   - operand
//   amt    - shift amount, 0..DATA_W-1
//   dir    - DIR_LEFT or DIR_RIGHT
//   result - shifted operand
module shift_core
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic              dir,
  output logic [DATA_W-1:0] result
);

  // stage_s[s] is the operand after the first s binary-weighted stages.
  logic [DATA_W-1:0] stage_s [AMT_W+1];

  assign stage_s[0] = data;

  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    // Stage s shifts by 2**s when amount bit s is set.
    assign stage_s[s+1] = !amt[s]           ? stage_s[s] :
                          (dir == DIR_LEFT) ? (stage_s[s] << (1 << s)) :
                                              (stage_s[s] >> (1 << s));
  end

  assign result = stage_s[AMT_W];

endmodule

// File: rtl/shift_arbiter_rr.sv
// Round-robin arbiter sharing one shift_core between NUM_REQ requesters.
// The winning request is shifted and captured in a single response slot
// returned with the requester index under valid/ready backpressure.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (req_ready one-hot or 0)
//   req_data/amt/dir      - packed per-requester operand, amount, direction
//   resp_valid/resp_ready - response slot handshake
//   resp_data, resp_id    - shifted result and issuing requester
//   grant_cnt_clr         - zero all grant counters
//   grant_cnt             - packed 16-bit saturating grant counters
module shift_arbiter_rr
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
  input  logic [NUM_REQ-1:0]        req_dir,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      grant_cnt_clr,
  output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
);

  slot_state_t       state_r;
  slot_state_t       state_next_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   grant_idx_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic              grant_any_s;
  logic              can_accept_s;
  shift_req_t        sel_req_s;
  logic [DATA_W-1:0] shift_res_s;
  logic [CNT_W-1:0]  cnt_r [NUM_REQ];

  // The slot can take a new result if empty or being drained this cycle.
  assign can_accept_s = (state_r == SLOT_EMPTY) || resp_ready;

  // Round-robin search starting at rr_ptr_r; first valid requester wins.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    grant_oh_s  = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!grant_any_s && can_accept_s && !rst && req_valid[idx_v]) begin
        grant_any_s        = 1'b1;
        grant_idx_s        = ID_W'(idx_v);
        grant_oh_s[idx_v]  = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // A grant is only issued to a valid requester, so a grant is a transfer.
  assign req_ready = grant_oh_s;

  // One-hot AND-OR mux of the granted requester's fields into the shifter.
  always_comb begin
    sel_req_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_req_s = sel_req_s | ({$bits(shift_req_t){grant_oh_s[i]}} &
                  {req_data[i*DATA_W +: DATA_W], req_amt[i*AMT_W +: AMT_W], req_dir[i]});
    end
  end

  shift_core u_shift_core (
    .data   (sel_req_s.data),
    .amt    (sel_req_s.amt),
    .dir    (sel_req_s.dir),
    .result (shift_res_s)
  );

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Slot next-state: a transfer always fills; a drain without refill empties.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (grant_any_s) state_next_s = SLOT_FULL;
        else             state_next_s = SLOT_EMPTY;
      end
      SLOT_FULL: begin
        if (grant_any_s)     state_next_s = SLOT_FULL;
        else if (resp_ready) state_next_s = SLOT_EMPTY;
        else                 state_next_s = SLOT_FULL;
      end
      default: state_next_s = SLOT_EMPTY;
    endcase
  end

  // Slot outputs decoded from the state register.
  always_comb begin
    case (state_r)
      SLOT_FULL:  resp_valid = 1'b1;
      SLOT_EMPTY: resp_valid = 1'b0;
      default:    resp_valid = 1'b0;
    endcase
  end

  // Response payload; keeps its last value when the slot drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data <= '0;
      resp_id   <= '0;
    end else if (grant_any_s) begin
      resp_data <= shift_res_s;
      resp_id   <= grant_idx_s;
    end else begin
      resp_data <= resp_data;
      resp_id   <= resp_id;
    end
  end

  // Priority pointer moves past the winner only when a transfer happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (grant_any_s) begin
      if (grant_idx_s == ID_W'(NUM_REQ - 1)) rr_ptr_r <= '0;
      else                                   rr_ptr_r <= grant_idx_s + ID_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || grant_cnt_clr) begin
        cnt_r[i] <= '0;
      end else if (grant_oh_s[i]) begin
        cnt_r[i] <= sat_inc(cnt_r[i]);
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end

endmodule

// File: tb/tb_shift_arbiter_rr.sv
// Self-checking bench for shift_arbiter_rr: a behavioural model checked on
// every falling edge plus directed vectors with literal expectations.
module tb_shift_arbiter_rr;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_data;
  logic [N*5-1:0]  req_amt;
  logic [N-1:0]  req_dir;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic [1:0]    resp_id;
  logic          grant_cnt_clr;
  logic [N*16-1:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  shift_arbiter_rr #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .req_amt       (req_amt),
    .req_dir       (req_dir),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_id       (resp_id),
    .grant_cnt_clr (grant_cnt_clr),
    .grant_cnt     (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic dr);
    req_data[i*32 +: 32] = d;
    req_amt[i*5 +: 5]    = a;
    req_dir[i]           = dr;
  endtask

  // ---------------- behavioural model ----------------
  // Slot contents, next-priority requester and grant counts, advanced once
  // per cycle at the falling edge using the inputs the next rising edge sees.
  int          m_live = 0;
  int          m_valid = 0;
  logic [31:0] m_data = 32'd0;
  int          m_id = 0;
  int          m_next = 0;
  int          m_cnt [N];
  int          m_win;
  int          m_bestd;
  logic [N-1:0] m_rdy;

  always @(negedge clk) begin
    if (m_live != 0) begin
      chk("model resp_valid", {31'd0, resp_valid}, m_valid[31:0]);
      chk("model resp_data", resp_data, m_data);
      chk("model resp_id", {30'd0, resp_id}, m_id[31:0]);
      for (int i = 0; i < N; i++)
        chk("model grant_cnt", {16'd0, grant_cnt[i*16 +: 16]}, m_cnt[i][31:0]);
    end
    // Winner: valid requester closest (cyclically) at or after m_next.
    m_win   = -1;
    m_bestd = N;
    if (!rst && (m_valid == 0 || resp_ready)) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && ((i - m_next + N) % N) < m_bestd) begin
          m_bestd = (i - m_next + N) % N;
          m_win   = i;
        end
      end
    end
    m_rdy = '0;
    if (m_win >= 0) m_rdy[m_win] = 1'b1;
    if (m_live != 0) chk("model req_ready", {28'd0, req_ready}, {28'd0, m_rdy});
    if (rst) begin
      m_live = 1; m_valid = 0; m_data = 32'd0; m_id = 0; m_next = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (m_win >= 0) begin
        if (req_dir[m_win]) m_data = req_data[m_win*32 +: 32] >> req_amt[m_win*5 +: 5];
        else                m_data = req_data[m_win*32 +: 32] << req_amt[m_win*5 +: 5];
        m_id    = m_win;
        m_valid = 1;
        m_next  = (m_win + 1) % N;
        if (m_cnt[m_win] < 65535) m_cnt[m_win] = m_cnt[m_win] + 1;
      end else if (resp_ready) begin
        m_valid = 0;
      end
      if (grant_cnt_clr)
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] tbl_amt [3];
  logic        tbl_dir [3];
  logic [31:0] tbl_exp [3];

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_amt = '0; req_dir = '0;
    resp_ready = 1'b1; grant_cnt_clr = 1'b0;
    tbl_amt[0] = 32'd31; tbl_dir[0] = 1'b1; tbl_exp[0] = 32'h0000_0001;
    tbl_amt[1] = 32'd31; tbl_dir[1] = 1'b0; tbl_exp[1] = 32'h8000_0000;
    tbl_amt[2] = 32'd0;  tbl_dir[2] = 1'b0; tbl_exp[2] = 32'h8000_0001;
    step(); step();
    @(negedge clk);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset req_ready", {28'd0, req_ready}, 32'd0);
    chk("reset grant_cnt", grant_cnt[31:0], 32'd0);

    // Single requester.
    step(); rst = 1'b0;
    set_req(0, 32'h0000_00F0, 5'd4, 1'b0); req_valid = 4'b0001;
    @(negedge clk);
    chk("single req_ready", {28'd0, req_ready}, 32'h1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("single resp_data", resp_data, 32'h0000_0F00);
    chk("single resp_id", {30'd0, resp_id}, 32'd0);
    chk("single grant_cnt0", {16'd0, grant_cnt[15:0]}, 32'd1);

    // Boundary amounts on requester 2.
    for (int t = 0; t < 3; t++) begin
      step();
      set_req(2, 32'h8000_0001, tbl_amt[t][4:0], tbl_dir[t]); req_valid = 4'b0100;
      step(); req_valid = '0;
      @(negedge clk);
      chk("boundary resp_data", resp_data, tbl_exp[t]);
      chk("boundary resp_id", {30'd0, resp_id}, 32'd2);
    end

    // Fairness from a fresh reset.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'h1111_1111 * (i + 1), 5'(i), 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 7) begin
        req_valid = 4'b1010; resp_ready = 1'b0;
      end
      @(negedge clk);
      chk("fair resp_id", {30'd0, resp_id}, 32'(k % 4));
    end
    for (int i = 0; i < N; i++)
      chk("fair grant_cnt", {16'd0, grant_cnt[i*16 +: 16]}, 32'd2);

    // Backpressure with requesters 1 and 3 waiting.
    repeat (5) step();
    @(negedge clk);
    chk("stall req_ready", {28'd0, req_ready}, 32'd0);
    chk("stall resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("stall resp_id", {30'd0, resp_id}, 32'd3);
    chk("stall resp_data", resp_data, 32'h2222_2220);
    step(); resp_ready = 1'b1;
    @(negedge clk);
    chk("release req_ready", {28'd0, req_ready}, 32'h2);
    step(); req_valid = 4'b1000;
    @(negedge clk);
    chk("release resp_id", {30'd0, resp_id}, 32'd1);
    chk("release resp_data", resp_data, 32'h4444_4444);
    chk("release req_ready2", {28'd0, req_ready}, 32'h8);
    step(); req_valid = '0;
    @(negedge clk);
    chk("release resp_id2", {30'd0, resp_id}, 32'd3);

    // Reset while a result is pending.
    step();
    set_req(0, 32'hDEAD_BEEF, 5'd0, 1'b0); req_valid = 4'b0001; resp_ready = 1'b0;
    step(); req_valid = '0;
    @(negedge clk);
    chk("pending resp_data", resp_data, 32'hDEAD_BEEF);
    step(); rst = 1'b1; set_req(3, 32'h1234_5678, 5'd4, 1'b1);
    step(); rst = 1'b0; req_valid = 4'b1111; resp_ready = 1'b1;
    @(negedge clk);
    chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst resp_data", resp_data, 32'd0);
    chk("midrst req_ready", {28'd0, req_ready}, 32'h1);
    step(); req_valid = 4'b1000;
    @(negedge clk);
    chk("midrst first id", {30'd0, resp_id}, 32'd0);
    step(); req_valid = '0;
    @(negedge clk);
    chk("midrst req3 id", {30'd0, resp_id}, 32'd3);
    chk("midrst req3 data", resp_data, 32'h0123_4567);

    // Saturation and clear-priority on requester 0.
    step(); grant_cnt_clr = 1'b1;
    step(); grant_cnt_clr = 1'b0; req_valid = 4'b0001;
    repeat (65535) step();
    @(negedge clk);
    chk("sat reach", {16'd0, grant_cnt[15:0]}, 32'h0000_FFFF);
    step();
    @(negedge clk);
    chk("sat hold", {16'd0, grant_cnt[15:0]}, 32'h0000_FFFF);
    step(); grant_cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr grant req_ready", {28'd0, req_ready}, 32'h1);
    step(); grant_cnt_clr = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("clr wins", {16'd0, grant_cnt[15:0]}, 32'd0);
    step();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
